llki_key_sequencer: RTL and testbench

LLKI_KEY_SEQUENCER -- requirements
Module: llki_key_sequencer

---
 rtl/llki_key_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_llki_key_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llki_key_sequencer.sv
// LLKI key sequencer: streams key words from a key store to the TSS, or issues a clear-key
// request, with a per-response timeout and a one-cycle response pulse.
module llki_key_sequencer #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned MAX_WORDS      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [7:0]        cmd_key_words,
    input  logic [ADDR_W-1:0] cmd_base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [63:0]       mem_rd_data,
    output logic [63:0]       llkid_key_data,
    output logic              llkid_key_valid,
    input  logic              llkid_key_ready,
    input  logic              llkid_key_complete,
    output logic              llkid_clear_key,
    input  logic              llkid_clear_key_ack,
    output logic              rsp_valid,
    output logic [1:0]        rsp_status,
    output logic [7:0]        words_sent,
    output logic              busy
);

    localparam logic [1:0] OpLoad        = 2'b00;
    localparam logic [1:0] OpClear       = 2'b01;
    localparam logic [1:0] StatusOk      = 2'b00;
    localparam logic [1:0] StatusTimeout = 2'b01;
    localparam logic [1:0] StatusBadCmd  = 2'b10;
    localparam logic [15:0] TmoLast      = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdWait,
        StSend,
        StWaitComplete,
        StClearReq,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        key_words_q, key_words_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        words_sent_q, words_sent_d;
    logic [15:0]       tmo_cnt_q, tmo_cnt_d;
    logic              tmo_flag_q, tmo_flag_d;
    logic [63:0]       key_data_q, key_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]        rsp_status_q, rsp_status_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rd_en_q, rd_en_d;
    logic              key_valid_q, key_valid_d;
    logic              clear_key_q, clear_key_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;

    logic [1:0] resp_code;
    logic       load_legal;
    logic       tmo_expired;
    logic       more_words;

    assign load_legal  = (cmd_op == OpLoad) && (cmd_key_words != 8'd0) &&
                         (32'(cmd_key_words) <= MAX_WORDS);
    assign tmo_expired = (tmo_cnt_q == TmoLast);
    assign more_words  = (words_sent_q + 8'd1) < key_words_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            key_words_q  <= '0;
            base_q       <= '0;
            words_sent_q <= '0;
            tmo_cnt_q    <= '0;
            tmo_flag_q   <= 1'b0;
            key_data_q   <= '0;
            rd_addr_q    <= '0;
            rsp_status_q <= '0;
            cmd_ready_q  <= 1'b1;
            rd_en_q      <= 1'b0;
            key_valid_q  <= 1'b0;
            clear_key_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_words_q  <= key_words_d;
            base_q       <= base_d;
            words_sent_q <= words_sent_d;
            tmo_cnt_q    <= tmo_cnt_d;
            tmo_flag_q   <= tmo_flag_d;
            key_data_q   <= key_data_d;
            rd_addr_q    <= rd_addr_d;
            rsp_status_q <= rsp_status_d;
            cmd_ready_q  <= cmd_ready_d;
            rd_en_q      <= rd_en_d;
            key_valid_q  <= key_valid_d;
            clear_key_q  <= clear_key_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        key_words_d  = key_words_q;
        base_d       = base_q;
        words_sent_d = words_sent_q;
        tmo_cnt_d    = tmo_cnt_q;
        tmo_flag_d   = tmo_flag_q;
        key_data_d   = key_data_q;
        resp_code    = StatusOk;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    tmo_flag_d = 1'b0;
                    if (cmd_op == OpClear) begin
                        state_d = StClearReq;
                    end else if (load_legal) begin
                        key_words_d  = cmd_key_words;
                        base_d       = cmd_base_addr;
                        words_sent_d = '0;
                        state_d      = StRdIssue;
                    end else begin
                        state_d   = StResp;
                        resp_code = StatusBadCmd;
                    end
                end
            end
            StRdIssue: state_d = StRdWait;
            StRdWait: begin
                // Key store returns data the cycle after the strobe.
                key_data_d = mem_rd_data;
                state_d    = StSend;
            end
            StSend: begin
                if (llkid_key_ready) begin
                    words_sent_d = words_sent_q + 8'd1;
                    state_d      = more_words ? StRdIssue : StWaitComplete;
                end else if (tmo_expired) begin
                    tmo_flag_d = 1'b1;
                    state_d    = StClearReq;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            StWaitComplete: begin
                if (llkid_key_complete) begin
                    state_d   = StResp;
                    resp_code = StatusOk;
                end else if (tmo_expired) begin
                    tmo_flag_d = 1'b1;
                    state_d    = StClearReq;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            StClearReq: begin
                // A scrub after a load timeout still reports timeout even when acked.
                if (llkid_clear_key_ack) begin
                    state_d   = StResp;
                    resp_code = tmo_flag_q ? StatusTimeout : StatusOk;
                end else if (tmo_expired) begin
                    state_d   = StResp;
                    resp_code = StatusTimeout;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if ((state_d != state_q) &&
            (state_d == StSend || state_d == StWaitComplete || state_d == StClearReq)) begin
            tmo_cnt_d = '0;
        end
    end

    // Outputs are decoded from the next state so they come straight from flops.
    always_comb begin
        cmd_ready_d  = (state_d == StIdle);
        rd_en_d      = (state_d == StRdIssue);
        key_valid_d  = (state_d == StSend);
        clear_key_d  = (state_d == StClearReq);
        rsp_valid_d  = (state_d == StResp);
        busy_d       = (state_d != StIdle);
        rd_addr_d    = rd_addr_q;
        rsp_status_d = rsp_status_q;
        if (state_d == StRdIssue) begin
            rd_addr_d = base_d + ADDR_W'(words_sent_d);
        end
        if (state_d == StResp) begin
            rsp_status_d = resp_code;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign mem_rd_en       = rd_en_q;
    assign mem_rd_addr     = rd_addr_q;
    assign llkid_key_data  = key_data_q;
    assign llkid_key_valid = key_valid_q;
    assign llkid_clear_key = clear_key_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_status      = rsp_status_q;
    assign words_sent      = words_sent_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_llki_key_sequencer.sv
// Bench for llki_key_sequencer: TSS and key-store models, event monitors and a
// transaction-level reference model with directed and random commands.
module tb_llki_key_sequencer;

    localparam int unsigned AddrW    = 8;
    localparam int unsigned MaxWords = 32;
    localparam int unsigned Tmo      = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_key_words;
    logic [7:0]  cmd_base_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_addr;
    logic [63:0] mem_rd_data = '0;
    logic [63:0] llkid_key_data;
    logic        llkid_key_valid;
    logic        llkid_key_ready = 1'b0;
    logic        llkid_key_complete = 1'b0;
    logic        llkid_clear_key;
    logic        llkid_clear_key_ack = 1'b0;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic [7:0]  words_sent;
    logic        busy;

    llki_key_sequencer #(
        .ADDR_W         (AddrW),
        .MAX_WORDS      (MaxWords),
        .TIMEOUT_CYCLES (Tmo)
    ) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_op              (cmd_op),
        .cmd_key_words       (cmd_key_words),
        .cmd_base_addr       (cmd_base_addr),
        .mem_rd_en           (mem_rd_en),
        .mem_rd_addr         (mem_rd_addr),
        .mem_rd_data         (mem_rd_data),
        .llkid_key_data      (llkid_key_data),
        .llkid_key_valid     (llkid_key_valid),
        .llkid_key_ready     (llkid_key_ready),
        .llkid_key_complete  (llkid_key_complete),
        .llkid_clear_key     (llkid_clear_key),
        .llkid_clear_key_ack (llkid_clear_key_ack),
        .rsp_valid           (rsp_valid),
        .rsp_status          (rsp_status),
        .words_sent          (words_sent),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Key store and TSS behaviour knobs.
    logic [63:0] mem [256];
    int  wait_states = 0;
    int  stop_after = 255;
    int  target = 0;
    bit  complete_en = 1'b0;
    bit  ack_en = 1'b1;
    bit  glitch = 1'b0;
    int  accepted = 0;
    int  wcnt = 0;
    int  ccnt = 0;
    bit  complete_given = 1'b0;
    bit  rd_pending = 1'b0;
    logic [7:0] rd_addr_l = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                llkid_key_ready     = 1'b0;
                llkid_key_complete  = 1'b0;
                llkid_clear_key_ack = 1'b0;
                rd_pending          = 1'b0;
                wcnt                = 0;
                ccnt                = 0;
            end else begin
                if (rd_pending) mem_rd_data = mem[rd_addr_l];
                else            mem_rd_data = {$urandom, $urandom};
                rd_pending = mem_rd_en;
                rd_addr_l  = mem_rd_addr;
                if (llkid_key_ready) accepted++;
                if (llkid_key_valid && accepted < stop_after) begin
                    if (wcnt >= wait_states) begin
                        llkid_key_ready = 1'b1;
                    end else begin
                        llkid_key_ready = 1'b0;
                        wcnt++;
                    end
                end else begin
                    llkid_key_ready = 1'b0;
                    wcnt            = 0;
                end
                if (accepted == target && complete_en && !complete_given) begin
                    llkid_key_complete = 1'b1;
                    complete_given     = 1'b1;
                end else begin
                    llkid_key_complete = glitch && llkid_key_valid && ($urandom_range(0, 1) != 0);
                end
                if (llkid_clear_key) begin
                    llkid_clear_key_ack = ack_en && (ccnt >= 1);
                    ccnt++;
                end else begin
                    ccnt                = 0;
                    llkid_clear_key_ack = glitch && llkid_key_valid &&
                                          ($urandom_range(0, 1) != 0);
                end
            end
        end
    end

    // Monitors, sampled on the falling edge.
    int cyc = 0;
    int acc_cyc = -1, first_rd = -1, first_valid = -1, first_clr = -1, rsp_cyc = -1;
    int rsp_cnt = 0, overlap = 0, unstable = 0, clr_cycles = 0, valid_cycles = 0;
    int max_run = 0, cur_run = 0;
    logic [7:0]  rd_q [$];
    logic [63:0] sent_q [$];
    logic [1:0]  rsp_st = '0;
    logic [7:0]  rsp_ws = '0;
    logic        prev_valid = 1'b0, prev_xfer = 1'b0;
    logic [63:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_valid && cmd_ready && acc_cyc < 0) acc_cyc <= cyc;
        if (mem_rd_en) begin
            rd_q.push_back(mem_rd_addr);
            if (first_rd < 0) first_rd <= cyc;
        end
        if (llkid_key_valid) begin
            valid_cycles <= valid_cycles + 1;
            if (first_valid < 0) first_valid <= cyc;
            cur_run <= cur_run + 1;
            if (cur_run + 1 > max_run) max_run <= cur_run + 1;
        end else begin
            cur_run <= 0;
        end
        if (llkid_key_valid && llkid_key_ready) sent_q.push_back(llkid_key_data);
        if (llkid_clear_key) begin
            clr_cycles <= clr_cycles + 1;
            if (first_clr < 0) first_clr <= cyc;
        end
        if (llkid_key_valid && llkid_clear_key) overlap <= overlap + 1;
        if (llkid_key_valid && prev_valid && !prev_xfer && llkid_key_data != prev_data)
            unstable <= unstable + 1;
        if (rsp_valid) begin
            rsp_cnt <= rsp_cnt + 1;
            rsp_cyc <= cyc;
            rsp_st  <= rsp_status;
            rsp_ws  <= words_sent;
        end
        prev_valid <= llkid_key_valid;
        prev_xfer  <= llkid_key_valid && llkid_key_ready;
        prev_data  <= llkid_key_data;
    end

    int exp_ws = 0;
    int txn_id = 0;

    task automatic setup_txn(input int words, input int wst, input int stop, input bit cen,
                             input bit aen, input bit glit);
        wait_states = wst; stop_after = stop; target = words; complete_en = cen;
        ack_en = aen; glitch = glit; accepted = 0; complete_given = 1'b0;
        acc_cyc = -1; first_rd = -1; first_valid = -1; first_clr = -1; rsp_cyc = -1;
        rsp_cnt = 0; overlap = 0; unstable = 0; clr_cycles = 0; valid_cycles = 0;
        max_run = 0;
        rd_q.delete();
        sent_q.delete();
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] words,
                            input logic [7:0] base);
        int n = 0;
        @(posedge clk);
        #2;
        cmd_valid = 1'b1; cmd_op = op; cmd_key_words = words; cmd_base_addr = base;
        while (acc_cyc < 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #2;
        cmd_valid     = 1'b0;
        cmd_op        = 2'($urandom);
        cmd_key_words = 8'($urandom);
        cmd_base_addr = 8'($urandom);
    endtask

    task automatic check_reset(input string t);
        check_value({t, " cmd_ready"},  64'(cmd_ready), 64'd1);
        check_value({t, " mem_rd_en"},  64'(mem_rd_en), 64'd0);
        check_value({t, " key_valid"},  64'(llkid_key_valid), 64'd0);
        check_value({t, " clear_key"},  64'(llkid_clear_key), 64'd0);
        check_value({t, " rsp_valid"},  64'(rsp_valid), 64'd0);
        check_value({t, " busy"},       64'(busy), 64'd0);
        check_value({t, " key_data"},   llkid_key_data, 64'd0);
        check_value({t, " rd_addr"},    64'(mem_rd_addr), 64'd0);
        check_value({t, " rsp_status"}, 64'(rsp_status), 64'd0);
        check_value({t, " words_sent"}, 64'(words_sent), 64'd0);
    endtask

    // Reference model: expected outcome of one command derived from the command rules.
    task automatic run_txn(input logic [1:0] op, input int words, input logic [7:0] base,
                           input int wst, input int stop, input bit cen, input bit aen,
                           input bit glit);
        bit         legal_load, tmo;
        int         exp_sent, exp_reads, exp_clr, n, lim;
        logic [1:0] exp_st;
        logic [7:0] a;
        string      t;
        t = $sformatf("txn%0d", txn_id);
        txn_id++;
        legal_load = (op == 2'b00) && words >= 1 && words <= int'(MaxWords);
        exp_sent = 0; exp_reads = 0; exp_clr = 0; exp_st = 2'b10; tmo = 1'b0;
        if (legal_load) begin
            exp_sent  = (stop < words) ? stop : words;
            exp_reads = (stop < words) ? stop + 1 : words;
            tmo       = (stop < words) || !cen;
            exp_clr   = tmo ? (aen ? 2 : int'(Tmo)) : 0;
            exp_st    = tmo ? 2'b01 : 2'b00;
            exp_ws    = exp_sent;
        end else if (op == 2'b01) begin
            exp_clr = aen ? 2 : int'(Tmo);
            exp_st  = aen ? 2'b00 : 2'b01;
        end
        setup_txn(words, wst, stop, cen, aen, glit);
        send_cmd(op, 8'(words), base);
        n = 0;
        while (rsp_cnt == 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #2;
        check_value({t, " rsp_count"}, 64'(rsp_cnt), 64'd1);
        check_value({t, " rsp_status"}, 64'(rsp_st), 64'(exp_st));
        check_value({t, " rsp_words"}, 64'(rsp_ws), 64'(exp_ws));
        check_value({t, " status_held"}, 64'(rsp_status), 64'(exp_st));
        check_value({t, " idle_busy"}, 64'(busy), 64'd0);
        check_value({t, " n_reads"}, 64'(rd_q.size()), 64'(exp_reads));
        check_value({t, " n_sent"}, 64'(sent_q.size()), 64'(exp_sent));
        check_value({t, " clear_cycles"}, 64'(clr_cycles), 64'(exp_clr));
        check_value({t, " overlap"}, 64'(overlap), 64'd0);
        check_value({t, " data_stable"}, 64'(unstable), 64'd0);
        lim = (rd_q.size() < exp_reads) ? rd_q.size() : exp_reads;
        for (int i = 0; i < lim; i++) begin
            a = base + 8'(i);
            check_value($sformatf("%s rd_addr%0d", t, i), 64'(rd_q[i]), 64'(a));
        end
        lim = (sent_q.size() < exp_sent) ? sent_q.size() : exp_sent;
        for (int i = 0; i < lim; i++) begin
            a = base + 8'(i);
            check_value($sformatf("%s word%0d", t, i), sent_q[i], mem[a]);
        end
        if (legal_load) begin
            check_value({t, " rd_latency"}, 64'(first_rd - acc_cyc), 64'd1);
            check_value({t, " valid_latency"}, 64'(first_valid - acc_cyc), 64'd3);
            if (stop < words) check_value({t, " valid_run"}, 64'(max_run), 64'(Tmo));
        end else begin
            check_value({t, " valid_cycles"}, 64'(valid_cycles), 64'd0);
            if (op == 2'b01) begin
                check_value({t, " clr_latency"}, 64'(first_clr - acc_cyc), 64'd1);
                check_value({t, " rsp_latency"}, 64'(rsp_cyc - acc_cyc),
                            aen ? 64'd3 : 64'(Tmo + 1));
            end else begin
                check_value({t, " rsp_latency"}, 64'(rsp_cyc - acc_cyc), 64'd1);
            end
        end
    endtask

    task automatic reset_mid_op();
        int n = 0;
        setup_txn(3, 1, 1, 1'b1, 1'b1, 1'b0);
        send_cmd(2'b00, 8'd3, 8'h80);
        while (!(accepted == 1 && llkid_key_valid) && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_value("midrst in_send", 64'(accepted == 1 && llkid_key_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_reset("midrst");
        repeat (2) @(posedge clk);
        #2;
        check_value("midrst no_rsp", 64'(rsp_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_ws = 0;
        run_txn(2'b01, 0, 8'h00, 0, 255, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [1:0] op;
        int         words, stop;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_key_words = '0; cmd_base_addr = '0;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        repeat (3) @(posedge clk);
        #2;
        check_reset("por");
        @(negedge clk);
        rst = 1'b0;

        run_txn(2'b00, 2, 8'hFE, 4, 255, 1'b1, 1'b1, 1'b0);
        run_txn(2'b00, 0, 8'h10, 0, 255, 1'b1, 1'b1, 1'b0);
        run_txn(2'b00, 33, 8'h10, 0, 255, 1'b1, 1'b1, 1'b0);
        run_txn(2'b11, 2, 8'h10, 0, 255, 1'b1, 1'b1, 1'b0);
        run_txn(2'b01, 0, 8'h00, 0, 255, 1'b1, 1'b1, 1'b0);
        run_txn(2'b00, 4, 8'h40, 2, 1, 1'b1, 1'b1, 1'b0);
        run_txn(2'b01, 0, 8'h00, 0, 255, 1'b0, 1'b0, 1'b0);
        reset_mid_op();
        run_txn(2'b00, int'(MaxWords), 8'hF0, 0, 255, 1'b1, 1'b1, 1'b1);

        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin
                    words = ($urandom_range(0, 4) == 0) ? int'(MaxWords) : $urandom_range(1, 10);
                    stop  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, words - 1) : 255;
                    run_txn(2'b00, words, 8'($urandom), $urandom_range(0, 5), stop,
                            $urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0,
                            $urandom_range(0, 1) != 0);
                end
                6, 7: run_txn(2'b01, $urandom_range(0, 255), 8'($urandom), 0, 255,
                              $urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0, 1'b0);
                default: begin
                    case ($urandom_range(0, 2))
                        0: begin op = 2'($urandom_range(2, 3)); words = $urandom_range(0, 255); end
                        1: begin op = 2'b00; words = 0; end
                        default: begin op = 2'b00; words = $urandom_range(33, 255); end
                    endcase
                    run_txn(op, words, 8'($urandom), 0, 255, 1'b1, 1'b1, 1'b0);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
